pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 12 +
 rtl/pred_queue.sv | 77 +++++++
 rtl/pc_gen.sv | 94 +++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared front-end definitions: prediction-queue entry layout and fetch-width default.
package pc_gen_pkg;

    localparam int FETCH_BYTES_DEF = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
    } pq_entry_t;

endpackage

// File: rtl/pred_queue.sv
// Synchronous prediction-queue FIFO with single-cycle flush; storage is not reset
// because the head is only meaningful while the occupancy is non-zero.
module pred_queue
    import pc_gen_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     clk_en_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  pq_entry_t                push_data_i,
    input  logic                     pop_i,
    output pq_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    pq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign push_ok_s = push_i && (count_q < CW'(DEPTH));
    assign pop_ok_s  = pop_i && (count_q != {CW{1'b0}});

    // Flush wins over push/pop; pointers wrap naturally at power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else if (clk_en_i) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && clk_en_i && !flush_i && push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/pc_gen.sv
// Next-fetch PC generator: combines BTB/direction hints into a predicted target and
// records every issued prediction in a queue until the backend resolves it.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          FETCH_BYTES = FETCH_BYTES_DEF,
    parameter int          PQ_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        clkEn,
    input  logic                        rst,
    output logic [63:0]                 btbPc,
    input  logic [63:0]                 btbDest,
    input  logic                        btbValid,
    input  logic                        btbUnconditional,
    input  logic                        dirTaken,
    output logic [63:0]                 fetchPc,
    output logic                        fetchValid,
    input  logic                        fetchReady,
    input  logic                        redirectValid,
    input  logic [63:0]                 redirectPc,
    input  logic                        resolveValid,
    output logic                        pqHeadValid,
    output logic [63:0]                 pqHeadPc,
    output logic                        pqHeadTaken,
    output logic [63:0]                 pqHeadTarget,
    output logic [$clog2(PQ_DEPTH):0]   pqCount
);

    localparam int          CW         = $clog2(PQ_DEPTH) + 1;
    localparam logic [63:0] ALIGN_MASK = ~(64'(FETCH_BYTES) - 64'd1);

    logic [63:0]   pc_q, pc_d;
    logic          pred_taken_s;
    logic [63:0]   pred_target_s;
    logic          transfer_s;
    logic [CW-1:0] count_s;
    pq_entry_t     head_s;
    pq_entry_t     push_data_s;

    assign pred_taken_s  = btbValid && (btbUnconditional || dirTaken);
    assign pred_target_s = pred_taken_s ? (btbDest & ALIGN_MASK)
                                        : ((pc_q + 64'(FETCH_BYTES)) & ALIGN_MASK);

    // A resolve in the same cycle does not open a slot for fetch.
    assign fetchValid = !rst && !redirectValid && (count_s < CW'(PQ_DEPTH));
    assign transfer_s = fetchValid && fetchReady && clkEn;

    // Redirect takes priority over the predicted path.
    always_comb begin
        pc_d = pc_q;
        if (redirectValid) begin
            pc_d = redirectPc & ALIGN_MASK;
        end else if (transfer_s) begin
            pc_d = pred_target_s;
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC & ALIGN_MASK;
        end else if (clkEn) begin
            pc_q <= pc_d;
        end
    end

    assign push_data_s = '{pc: pc_q, taken: pred_taken_s, target: pred_target_s};

    pred_queue #(
        .DEPTH (PQ_DEPTH)
    ) u_pred_queue (
        .clk_i       (clk),
        .clk_en_i    (clkEn),
        .rst_i       (rst),
        .flush_i     (redirectValid),
        .push_i      (transfer_s),
        .push_data_i (push_data_s),
        .pop_i       (resolveValid),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    assign btbPc        = pc_q;
    assign fetchPc      = pc_q;
    assign pqCount      = rst ? {CW{1'b0}} : count_s;
    assign pqHeadValid  = !rst && (count_s != {CW{1'b0}});
    assign pqHeadPc     = head_s.pc;
    assign pqHeadTaken  = head_s.taken;
    assign pqHeadTarget = head_s.target;

endmodule
